// File: rtl/vga_sink_pkg.sv
// Shared constants, drain-state encoding and pure helper functions for the VGA bus sink.
// Used by vga_bus_sink (optional write counter enabled with VGA_SINK_WR_COUNT_EN).
package vga_sink_pkg;

  localparam int VGA_X_RES_DEF = 160;
  localparam int VGA_Y_RES_DEF = 120;

  localparam logic [1:0] DRAIN_EMPTY   = 2'd0;
  localparam logic [1:0] DRAIN_FILLING = 2'd1;
  localparam logic [1:0] DRAIN_FULL    = 2'd2;

  typedef enum logic [1:0] {
    S_EMPTY   = DRAIN_EMPTY,
    S_FILLING = DRAIN_FILLING,
    S_FULL    = DRAIN_FULL
  } drain_state_e;

  // Smallest address width that covers every visible pixel.
  function automatic int addr_width(input int x_res, input int y_res);
    return $clog2(x_res * y_res);
  endfunction

  // Keeps the top ch_bits of each channel; result is {R,G,B} right-aligned.
  function automatic logic [23:0] pack_colour(input logic [23:0] rgb, input int ch_bits);
    logic [23:0] packed_rgb;
    packed_rgb = '0;
    for (int i = 0; i < ch_bits; i++) begin
      packed_rgb[2*ch_bits + i] = rgb[24 - ch_bits + i];
      packed_rgb[ch_bits + i]   = rgb[16 - ch_bits + i];
      packed_rgb[i]             = rgb[8 - ch_bits + i];
    end
    return packed_rgb;
  endfunction

endpackage

// File: rtl/vga_pixel_fifo.sv
// Synchronous FIFO with a registered head slot; the head register counts as one of
// the DEPTH entries, so a write into an empty FIFO becomes visible one edge later.
module vga_pixel_fifo #(
  parameter  int WIDTH = 18,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count,
  output logic [WIDTH-1:0] o_head
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_head;
  logic             r_head_valid;

  logic             w_pop;
  logic             w_push;
  logic [CNT_W-1:0] w_mem_cnt;
  logic             w_load;

  assign w_pop     = i_pop & r_head_valid;
  assign w_push    = i_push & ((r_count != CNT_FULL) | w_pop);
  assign w_mem_cnt = r_count - CNT_W'(r_head_valid);
  // Refill the head whenever it is vacant or leaving, so pops run back-to-back.
  assign w_load    = (~r_head_valid | w_pop) & (w_mem_cnt != '0);

  // NOTE: the storage array has no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_head       <= '0;
      r_head_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_load) begin
        r_head       <= r_mem[r_rd_ptr];
        r_head_valid <= 1'b1;
        r_rd_ptr     <= r_rd_ptr + PTR_W'(1);
      end else if (w_pop) begin
        r_head_valid <= 1'b0;
      end
    end
  end

  assign o_full  = (r_count == CNT_FULL);
  assign o_empty = ~r_head_valid;
  assign o_count = r_count;
  assign o_head  = r_head;

endmodule

// File: rtl/vga_bus_sink.sv
// Receiving end of the shared VGA pixel bus: capture, clip, address/colour packing and
// a buffered req/ack framebuffer write port. VGA_SINK_WR_COUNT_EN adds the wr_count output.
module vga_bus_sink
  import vga_sink_pkg::*;
#(
  parameter int X_RES          = VGA_X_RES_DEF,
  parameter int Y_RES          = VGA_Y_RES_DEF,
  parameter int COLOUR_CH_BITS = 1,
  parameter int FIFO_DEPTH     = 8,
  parameter int ADDR_W         = addr_width(X_RES, Y_RES)
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [7:0]                  vga_x_in,
  input  logic [7:0]                  vga_y_in,
  input  logic [23:0]                 vga_RGB_in,
  input  logic                        vga_draw_enable_in,
  output logic [ADDR_W-1:0]           fb_addr,
  output logic [3*COLOUR_CH_BITS-1:0] fb_colour,
  output logic                        fb_wr_req,
  input  logic                        fb_wr_ack,
  input  logic                        clr_stats,
  output logic                        overflow,
  output logic [7:0]                  dropped_count,
  output logic                        busy
`ifdef VGA_SINK_WR_COUNT_EN
  ,
  output logic [16:0]                 wr_count
`endif
);

  localparam int COL_W = 3 * COLOUR_CH_BITS;
  localparam int DATA_W = ADDR_W + COL_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [ADDR_W:0]  X_RES_W    = (ADDR_W + 1)'(X_RES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ALMOST = CNT_W'(FIFO_DEPTH - 1);

  if ((64'd1 << ADDR_W) < 64'(X_RES * Y_RES)) begin : g_addr_w_check
    $error("vga_bus_sink: ADDR_W cannot address X_RES*Y_RES pixels");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
    $error("vga_bus_sink: FIFO_DEPTH must be a power of two >= 2");
  end

  logic        r_cap_valid;
  logic [7:0]  r_cap_x;
  logic [7:0]  r_cap_y;
  logic [23:0] r_cap_rgb;

  // Only a clean 1 counts as a strobe; X/Z from an undriven bus falls into the else branch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cap_valid <= 1'b0;
      r_cap_x     <= '0;
      r_cap_y     <= '0;
      r_cap_rgb   <= '0;
    end else if (vga_draw_enable_in == 1'b1) begin
      r_cap_valid <= 1'b1;
      r_cap_x     <= vga_x_in;
      r_cap_y     <= vga_y_in;
      r_cap_rgb   <= vga_RGB_in;
    end else begin
      r_cap_valid <= 1'b0;
    end
  end

  logic              w_in_range;
  logic [ADDR_W-1:0] w_addr;
  logic [COL_W-1:0]  w_colour;
  logic              w_push_req;

  assign w_in_range = (int'(r_cap_x) < X_RES) && (int'(r_cap_y) < Y_RES);
  assign w_addr     = ADDR_W'(((ADDR_W + 1)'(r_cap_y) * X_RES_W) + (ADDR_W + 1)'(r_cap_x));
  assign w_colour   = COL_W'(pack_colour(r_cap_rgb, COLOUR_CH_BITS));
  assign w_push_req = r_cap_valid & w_in_range;

  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [CNT_W-1:0]  w_fifo_count;
  logic [DATA_W-1:0] w_head;

  vga_pixel_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (resetn),
    .i_push      (w_push_req),
    .i_push_data ({w_addr, w_colour}),
    .i_pop       (fb_wr_ack),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count),
    .o_head      (w_head)
  );

  logic w_pop;
  logic w_push_acc;
  logic w_drop;

  assign w_pop      = fb_wr_ack & ~w_fifo_empty;
  assign w_push_acc = w_push_req & (~w_fifo_full | w_pop);
  assign w_drop     = w_push_req & w_fifo_full & ~w_pop;

  drain_state_e r_state;
  drain_state_e w_state_next;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: the default assignment before the case keeps this block free of inferred latches.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_EMPTY: begin
        if (w_push_acc) begin
          w_state_next = S_FILLING;
        end
      end
      S_FILLING: begin
        if (w_push_acc && !w_pop && (w_fifo_count == CNT_ALMOST)) begin
          w_state_next = S_FULL;
        end else if (!w_push_acc && w_pop && (w_fifo_count == CNT_ONE)) begin
          w_state_next = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_pop && !w_push_acc) begin
          w_state_next = S_FILLING;
        end
      end
      default: w_state_next = S_EMPTY;
    endcase
  end

  logic       r_overflow;
  logic [7:0] r_dropped;

  // A drop on the same edge as clr_stats wins: the cleared stats restart from this drop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_overflow <= 1'b0;
      r_dropped  <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clr_stats) begin
        r_dropped <= 8'd1;
      end else if (r_dropped != 8'hFF) begin
        r_dropped <= r_dropped + 8'd1;
      end
    end else if (clr_stats) begin
      r_overflow <= 1'b0;
      r_dropped  <= '0;
    end
  end

`ifdef VGA_SINK_WR_COUNT_EN
  logic [16:0] r_wr_count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_count <= '0;
    end else if (clr_stats) begin
      r_wr_count <= w_pop ? 17'd1 : 17'd0;
    end else if (w_pop) begin
      r_wr_count <= r_wr_count + 17'd1;
    end
  end

  assign wr_count = r_wr_count;
`endif

  assign fb_wr_req     = ~w_fifo_empty;
  assign fb_addr       = w_head[DATA_W-1:COL_W];
  assign fb_colour     = w_head[COL_W-1:0];
  assign overflow      = r_overflow;
  assign dropped_count = r_dropped;
  assign busy          = r_cap_valid | (r_state != S_EMPTY);

endmodule

// File: tb/tb_vga_bus_sink.sv
// Directed self-checking bench for vga_bus_sink: vector table plus hand-written
// latency, overflow, push+pop-at-full, async reset and full-screen sweep sequences.
module tb_vga_bus_sink;

  logic        clk;
  logic        resetn;
  logic [7:0]  vga_x_in;
  logic [7:0]  vga_y_in;
  logic [23:0] vga_RGB_in;
  logic        vga_draw_enable_in;
  logic [14:0] fb_addr;
  logic [2:0]  fb_colour;
  logic        fb_wr_req;
  logic        fb_wr_ack;
  logic        clr_stats;
  logic        overflow;
  logic [7:0]  dropped_count;
  logic        busy;
`ifdef VGA_SINK_WR_COUNT_EN
  logic [16:0] wr_count;
`endif

  vga_bus_sink dut (
    .clk                (clk),
    .resetn             (resetn),
    .vga_x_in           (vga_x_in),
    .vga_y_in           (vga_y_in),
    .vga_RGB_in         (vga_RGB_in),
    .vga_draw_enable_in (vga_draw_enable_in),
    .fb_addr            (fb_addr),
    .fb_colour          (fb_colour),
    .fb_wr_req          (fb_wr_req),
    .fb_wr_ack          (fb_wr_ack),
    .clr_stats          (clr_stats),
    .overflow           (overflow),
    .dropped_count      (dropped_count),
    .busy               (busy)
`ifdef VGA_SINK_WR_COUNT_EN
    ,
    .wr_count           (wr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [14:0] addr;
    logic [2:0]  colour;
  } wr_t;

  wr_t wr_log[$];

  // A write is logged half a cycle ahead of the edge on which it completes.
  always @(negedge clk) begin
    if (resetn && fb_wr_req && fb_wr_ack) begin
      wr_log.push_back({fb_addr, fb_colour});
    end
  end

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [23:0] rgb;
    bit          exp_wr;
    logic [14:0] exp_addr;
    logic [2:0]  exp_colour;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] x, input logic [7:0] y, input logic [23:0] rgb);
    vga_draw_enable_in = 1'b1;
    vga_x_in           = x;
    vga_y_in           = y;
    vga_RGB_in         = rgb;
  endtask

  task automatic idle();
    vga_draw_enable_in = 1'b0;
    vga_x_in           = 'x;
    vga_y_in           = 'x;
    vga_RGB_in         = 'x;
  endtask

  function automatic logic [23:0] rgb_of(input int i);
    logic [2:0] c;
    c = 3'(i);
    return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;

    vecs[0] = '{8'd5,   8'd2,   24'hFF00FF, 1'b1, 15'd325,   3'b101};
    vecs[1] = '{8'd0,   8'd0,   24'h000000, 1'b1, 15'd0,     3'b000};
    vecs[2] = '{8'd159, 8'd119, 24'hFFFFFF, 1'b1, 15'd19199, 3'b111};
    vecs[3] = '{8'd10,  8'd1,   24'h80FF7F, 1'b1, 15'd170,   3'b110};
    vecs[4] = '{8'd159, 8'd0,   24'h7F8000, 1'b1, 15'd159,   3'b010};
    vecs[5] = '{8'd0,   8'd1,   24'h000080, 1'b1, 15'd160,   3'b001};
    vecs[6] = '{8'd160, 8'd0,   24'hFFFFFF, 1'b0, 15'd0,     3'b000};
    vecs[7] = '{8'd0,   8'd120, 24'hFFFFFF, 1'b0, 15'd0,     3'b000};
    vecs[8] = '{8'd255, 8'd255, 24'hFFFFFF, 1'b0, 15'd0,     3'b000};

    resetn    = 1'b0;
    fb_wr_ack = 1'b0;
    clr_stats = 1'b0;
    idle();
    repeat (3) tick();
    check("rst_req", 32'(fb_wr_req), 0);
    check("rst_addr", 32'(fb_addr), 0);
    check("rst_colour", 32'(fb_colour), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_dropped", 32'(dropped_count), 0);
    check("rst_busy", 32'(busy), 0);
`ifdef VGA_SINK_WR_COUNT_EN
    check("rst_wr_count", 32'(wr_count), 0);
`endif
    resetn = 1'b1;
    tick();

    // Single pixel latency: sampled at edge N, req visible after N+2, gone after N+3.
    wr_log.delete();
    fb_wr_ack = 1'b1;
    drive(8'd5, 8'd2, 24'hFF00FF);
    tick();
    idle();
    check("lat_n_req", 32'(fb_wr_req), 0);
    check("lat_n_busy", 32'(busy), 1);
    tick();
    check("lat_n1_req", 32'(fb_wr_req), 0);
    tick();
    check("lat_n2_req", 32'(fb_wr_req), 1);
    check("lat_n2_addr", 32'(fb_addr), 325);
    check("lat_n2_colour", 32'(fb_colour), 5);
    tick();
    check("lat_n3_req", 32'(fb_wr_req), 0);
    check("lat_writes", 32'(wr_log.size()), 1);

    // Vector table: one strobe each, ack held high.
    for (int i = 0; i < 9; i++) begin
      wr_log.delete();
      drive(vecs[i].x, vecs[i].y, vecs[i].rgb);
      tick();
      idle();
      repeat (6) tick();
      check($sformatf("vec%0d_writes", i), 32'(wr_log.size()), vecs[i].exp_wr ? 1 : 0);
      if (vecs[i].exp_wr && wr_log.size() > 0) begin
        check($sformatf("vec%0d_addr", i), 32'(wr_log[0].addr), 32'(vecs[i].exp_addr));
        check($sformatf("vec%0d_colour", i), 32'(wr_log[0].colour), 32'(vecs[i].exp_colour));
      end
    end
    check("vec_dropped", 32'(dropped_count), 0);
    check("vec_overflow", 32'(overflow), 0);
    check("vec_busy", 32'(busy), 0);

    // Overflow: 12 strobes with ack low, 8 kept and 4 dropped.
    wr_log.delete();
    fb_wr_ack = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive(8'(i), 8'd3, rgb_of(i));
      tick();
    end
    idle();
    repeat (4) tick();
    check("ovf_dropped", 32'(dropped_count), 4);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_req", 32'(fb_wr_req), 1);
    check("ovf_head_addr", 32'(fb_addr), 480);
    repeat (3) tick();
    check("ovf_hold_addr", 32'(fb_addr), 480);
    check("ovf_hold_colour", 32'(fb_colour), 0);
    check("ovf_hold_req", 32'(fb_wr_req), 1);

    // Drop landing on the same edge as clr_stats restarts the stats at one.
    drive(8'd20, 8'd3, 24'hFFFFFF);
    tick();
    idle();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("clrdrop_dropped", 32'(dropped_count), 1);
    check("clrdrop_flag", 32'(overflow), 1);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("clr_dropped", 32'(dropped_count), 0);
    check("clr_flag", 32'(overflow), 0);

    fb_wr_ack = 1'b1;
    repeat (14) tick();
    check("ovf_writes", 32'(wr_log.size()), 8);
    bad = 0;
    foreach (wr_log[k]) begin
      if (wr_log[k].addr != 15'(480 + k) || wr_log[k].colour != 3'(k)) bad++;
    end
    check("ovf_order", 32'(bad), 0);
    check("ovf_drain_busy", 32'(busy), 0);

    // Push+pop while full: a strobe per cycle with ack high never drops.
    wr_log.delete();
    fb_wr_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(8'(i), 8'd5, rgb_of(i));
      tick();
    end
    idle();
    repeat (4) tick();
    check("full_req", 32'(fb_wr_req), 1);
    drive(8'd8, 8'd5, rgb_of(8));
    tick();
    fb_wr_ack = 1'b1;
    for (int i = 9; i < 28; i++) begin
      drive(8'(i), 8'd5, rgb_of(i));
      tick();
    end
    idle();
    repeat (15) tick();
    check("full_dropped", 32'(dropped_count), 0);
    check("full_overflow", 32'(overflow), 0);
    check("full_writes", 32'(wr_log.size()), 28);
    bad = 0;
    foreach (wr_log[k]) begin
      if (wr_log[k].addr != 15'(800 + k) || wr_log[k].colour != 3'(k)) bad++;
    end
    check("full_order", 32'(bad), 0);

    // Async reset mid-burst with five entries buffered.
    wr_log.delete();
    fb_wr_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(8'(i), 8'd7, 24'hFFFFFF);
      tick();
    end
    drive(8'd5, 8'd7, 24'hFFFFFF);
    tick();
    check("prerst_req", 32'(fb_wr_req), 1);
    check("prerst_busy", 32'(busy), 1);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_req", 32'(fb_wr_req), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_dropped", 32'(dropped_count), 0);
    check("arst_overflow", 32'(overflow), 0);
    idle();
    repeat (2) tick();
    resetn    = 1'b1;
    fb_wr_ack = 1'b1;
    repeat (10) tick();
    check("arst_stale_writes", 32'(wr_log.size()), 0);
    check("arst_after_busy", 32'(busy), 0);

    // Full-screen sweep in screen_refresh order.
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    wr_log.delete();
    for (int cnt = 0; cnt < 65536; cnt++) begin
      drive(cnt[7:0], cnt[15:8], 24'h000000);
      tick();
    end
    idle();
    repeat (10) tick();
    check("sweep_writes", 32'(wr_log.size()), 19200);
    bad = 0;
    foreach (wr_log[k]) begin
      if (wr_log[k].addr != 15'(k) || wr_log[k].colour != 3'd0) bad++;
    end
    check("sweep_order", 32'(bad), 0);
    check("sweep_dropped", 32'(dropped_count), 0);
    check("sweep_busy", 32'(busy), 0);
`ifdef VGA_SINK_WR_COUNT_EN
    check("sweep_wr_count", 32'(wr_count), 19200);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_bus_sink.md
Name: vga_bus_sink

Overview:
- Receiving end of the shared tri-stated VGA pixel bus (x, y, RGB, draw_enable) driven by screen_refresh and the tile drawers.
- Samples every asserted draw strobe and clips it to the visible area.
- Converts the 24-bit RGB to adapter colour depth and computes the linear framebuffer address.
- Buffers writes in a small FIFO, drained to the framebuffer write port through a req/ack handshake.

Parameters:
- X_RES, 160, visible width in pixels (x >= X_RES is clipped)
- Y_RES, 120, visible height in pixels (y >= Y_RES is clipped)
- COLOUR_CH_BITS, 1, bits kept per colour channel
- FIFO_DEPTH, 8, buffered writes; power of two, >= 2
- ADDR_W, 15, framebuffer address width; must satisfy 2^ADDR_W >= X_RES*Y_RES

Ports:
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- vga_x_in  in  8  bus x coordinate
- vga_y_in  in  8  bus y coordinate
- vga_RGB_in  in  24  bus colour, R[23:16] G[15:8] B[7:0]
- vga_draw_enable_in  in  1  bus pixel strobe; only 1'b1 counts as a pixel
- fb_addr  out  ADDR_W  framebuffer address, y*X_RES + x
- fb_colour  out  3*COLOUR_CH_BITS  packed {R,G,B} colour
- fb_wr_req  out  1  write request, high while FIFO is non-empty
- fb_wr_ack  in  1  framebuffer accepts the write this cycle
- clr_stats  in  1  synchronous clear of overflow and dropped_count
- overflow  out  1  sticky flag: at least one pixel dropped because the FIFO was full
- dropped_count  out  8  pixels dropped on full FIFO, saturates at 8'hFF
- busy  out  1  capture stage valid or FIFO non-empty

Behaviour:
- Reset (resetn low, asynchronous):
  - Capture stage invalid, FIFO empty.
  - fb_wr_req=0, fb_addr=0, fb_colour=0.
  - overflow=0, dropped_count=0, busy=0.
- Reset mid-operation discards all buffered and in-flight pixels, with no partial write.
- Stage 1 (capture), on each edge:
  - cap_valid <= (vga_draw_enable_in==1).
  - Registers x, y, RGB.
  - X/Z values on x/y/RGB while the strobe is low are ignored.
- Clip:
  - In range: cap_x < X_RES and cap_y < Y_RES.
  - Out-of-range pixels are silently discarded; they do not count as dropped.
- Arithmetic:
  - addr = cap_y*X_RES + cap_x, computed in ADDR_W+1 bits, truncated to ADDR_W.
  - Colour = top COLOUR_CH_BITS of each channel: {R[7-:C], G[7-:C], B[7-:C]}.
- Stage 2 (push): in-range cap_valid pushes {addr, colour} into the FIFO on the next edge.
- Latency: strobe sampled at edge N → fb_wr_req high after edge N+2 at the earliest (FIFO output registered).
- Output handshake:
  - fb_wr_req = !empty; fb_addr/fb_colour show the FIFO head.
  - A write completes on an edge with fb_wr_req & fb_wr_ack; the head then advances.
  - Outputs stay stable while req=1 and ack=0.
  - ack while req=0 is ignored.
- Full:
  - A push is accepted when count < FIFO_DEPTH, or when a pop occurs on the same edge; count is then unchanged.
  - Otherwise the pixel is dropped: overflow <= 1, dropped_count increments (saturating).
- clr_stats:
  - Clears overflow and dropped_count.
  - A drop on the same edge wins: overflow=1, count=1.
- Ordering: strict FIFO; writes reach the framebuffer in bus order.
- FSM of the drain side:
  - States EMPTY (count=0), FILLING (0 < count < DEPTH), FULL (count=DEPTH).
  - Transitions are driven by push/pop.
  - FULL→FULL on a simultaneous push+pop.
- Back-to-back strobes (one per cycle, as screen_refresh issues) are sustained with ack held high, with no drops.

Optional Feature:
- Macro: VGA_SINK_WR_COUNT_EN.
- Defined:
  - Adds output wr_count [16:0], reset to 0.
  - Increments on each completed framebuffer write; wraps at 2^17.
  - Cleared by clr_stats; a same-edge write makes it 1.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package vga_sink_pkg:
  - Default X_RES/Y_RES constants.
  - Colour-packing function.
  - Address-width helper function.
  - Drain-state localparams.
- One sub-module, vga_pixel_fifo:
  - Synchronous, parameterised width/depth.
  - Registered head, push/pop/full/empty/count ports.
  - Async active-low reset.

Test Plan:
- Single pixel: strobe x=5, y=2, RGB=24'hFF00FF, ack=1 → one write, fb_addr=325, fb_colour=3'b101; req rises 2 edges after the sample and is high 1 cycle.
- Clip: strobes at (160,0), (0,120), (255,255) → no fb_wr_req; dropped_count=0; busy returns low.
- Overflow: ack=0, 12 consecutive in-range strobes → 8 buffered, dropped_count=4, overflow=1. Then ack=1 → exactly the first 8 pixels are written in order. clr_stats → both cleared.
- Full-screen sweep, screen_refresh style: 65536 strobes, x=cnt[7:0], y=cnt[15:8], RGB=0, ack=1 → exactly 19200 writes, addresses 0..19199 ascending, colour 0, no drops.
- Push+pop at full: FIFO full, ack=1 with a strobe every cycle for 20 cycles → count stays 8, dropped_count=0.
- Async reset: assert resetn=0 mid-burst with the FIFO at 5 entries → immediately fb_wr_req=0, busy=0, stats 0. After release, no stale writes appear.
- With VGA_SINK_WR_COUNT_EN, the same sweep → wr_count=19200.
